dg0045_display_scan: RTL and testbench

//   Downstream display stage for the DG0045 4-bit core. Consumes the core's Lreg

---
 rtl/dg0045_display_scan_if.sv | 16 +
 rtl/dg0045_display_scan.sv | 112 +++++++++++
 tb/tb_dg0045_display_scan.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/dg0045_display_scan_if.sv
// Core-to-display link for dg0045_display_scan: Lreg nibble, strobe and clear in,
// multiplexed segment/digit drive and status out.
interface dg0045_display_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [3:0]            nL;
    logic                  ND;
    logic                  clr;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] dig_n;
    logic                  frame_tick;
    logic [3:0]            digit_count;

    modport master (output nL, ND, clr, input seg, dig_n, frame_tick, digit_count);
    modport slave  (input nL, ND, clr, output seg, dig_n, frame_tick, digit_count);
endinterface

// File: rtl/dg0045_display_scan.sv
// DG0045 display stage: captures one Lreg nibble per ND strobe into a digit shift
// buffer and scans it onto a 7-seg display. HEX_DECODE_EN selects hex decode vs raw nibble.
module dg0045_display_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    RESET,
    dg0045_display_scan_if.slave    bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic                        nd_s1, nd_s2, nd_s3;
    logic [3:0]                  nl_s1, nl_s2;
    logic                        cap;
    logic [NUM_DIGITS-1:0][3:0]  digit;
    logic [NUM_DIGITS-1:0]       valid;
    logic [PW-1:0]               presc;
    logic [IW-1:0]               idx;
    logic                        slot_end;

    function automatic logic [6:0] decode(input logic [3:0] n);
`ifdef HEX_DECODE_EN
        case (n)
            4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;  default: decode = 7'h71;
        endcase
`else
        decode = {3'b000, n};
`endif
    endfunction

    // Equal-depth synchronisers keep nL aligned with the ND edge; nd_s3 is the edge detector
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            nd_s1 <= 1'b1;
            nd_s2 <= 1'b1;
            nd_s3 <= 1'b1;
            nl_s1 <= 4'hF;
            nl_s2 <= 4'hF;
        end else begin
            nd_s1 <= bus.ND;
            nd_s2 <= nd_s1;
            nd_s3 <= nd_s2;
            nl_s1 <= bus.nL;
            nl_s2 <= nl_s1;
        end
    end

    assign cap = nd_s2 & ~nd_s3;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            digit           <= '0;
            valid           <= '0;
            bus.digit_count <= 4'd0;
        end else if (cap) begin
            digit <= {digit[NUM_DIGITS-2:0], ~nl_s2};
            if (bus.clr) begin
                valid           <= NUM_DIGITS'(1);
                bus.digit_count <= 4'd1;
            end else begin
                valid <= {valid[NUM_DIGITS-2:0], 1'b1};
                if (bus.digit_count != 4'(NUM_DIGITS))
                    bus.digit_count <= bus.digit_count + 4'd1;
            end
        end else if (bus.clr) begin
            valid           <= '0;
            bus.digit_count <= 4'd0;
        end
    end

    assign slot_end = (presc == PW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            presc          <= '0;
            idx            <= '0;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.frame_tick <= slot_end && (idx == IW'(NUM_DIGITS - 1));
            if (slot_end) begin
                presc <= '0;
                idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Registered drive: reflects the index/prescaler of the previous cycle
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            bus.seg   <= 7'h00;
            bus.dig_n <= '1;
        end else if (presc < PW'(BLANK_CYCLES) || !valid[idx]) begin
            bus.seg   <= 7'h00;
            bus.dig_n <= '1;
        end else begin
            bus.seg   <= decode(digit[idx]);
            bus.dig_n <= ~(NUM_DIGITS'(1) << idx);
        end
    end
endmodule

// File: tb/tb_dg0045_display_scan.sv
// Directed bench for dg0045_display_scan with SCAN_DIV=8, BLANK_CYCLES=2 (32-clk frames).
module tb_dg0045_display_scan;
    localparam int ND_W = 4;
    localparam int SD   = 8;
    localparam int BC   = 2;

    logic clk = 1'b0;
    logic RESET = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dg0045_display_scan_if #(.NUM_DIGITS(ND_W)) bus ();

    dg0045_display_scan #(.NUM_DIGITS(ND_W), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    function automatic logic [6:0] exp_seg(input logic [3:0] n);
`ifdef HEX_DECODE_EN
        case (n)
            4'h2: exp_seg = 7'h5B;
            4'h5: exp_seg = 7'h6D;
            4'h7: exp_seg = 7'h07;
            4'hA: exp_seg = 7'h77;
            default: exp_seg = 7'h7F;
        endcase
`else
        exp_seg = {3'b000, n};
`endif
    endfunction

    task automatic wait_frame();
        int n = 0;
        @(negedge clk);
        while (bus.frame_tick !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL frame_timeout: no frame_tick within 100 clk");
        end
    endtask

    // Land on the registered output for slot s, prescaler p
    task automatic at_slot(input int s, input int p);
        wait_frame();
        repeat (s * SD + p + 1) @(negedge clk);
    endtask

    task automatic strobe(input logic [3:0] v);
        bus.nL = ~v;
        repeat (3) @(negedge clk);
        bus.ND = 1'b0;
        repeat (2) @(negedge clk);
        bus.ND = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_slot(input string nm, input int s, input logic [3:0] de, input logic [6:0] se);
        at_slot(s, BC + 1);
        checks++;
        if (bus.dig_n !== de || bus.seg !== se) begin
            errors++;
            $display("FAIL %s: dig_n=%b seg=%h required dig_n=%b seg=%h", nm, bus.dig_n, bus.seg, de, se);
        end
    endtask

    task automatic count_to_tick(input string nm);
        int n = 0;
        while (bus.frame_tick !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 4 * SD) begin
            errors++;
            $display("FAIL %s: first frame_tick after %0d clk, required %0d", nm, n, 4 * SD);
        end
    endtask

    task automatic test_reset();
        int lows = 0, ticks = 0;
        bus.nL = 4'hF; bus.ND = 1'b1; bus.clr = 1'b0;
        RESET = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.seg !== 7'h00 || bus.dig_n !== 4'b1111 || bus.digit_count !== 4'd0 || bus.frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: seg=%h dig_n=%b cnt=%0d tick=%b required 00 1111 0 0",
                     bus.seg, bus.dig_n, bus.digit_count, bus.frame_tick);
        end
        RESET = 1'b1;
        count_to_tick("reset_first_tick");
        for (int i = 0; i < 2 * 4 * SD; i++) begin
            @(negedge clk);
            if (bus.dig_n !== 4'b1111) lows++;
            if (bus.frame_tick === 1'b1) ticks++;
        end
        checks++;
        if (lows != 0) begin
            errors++;
            $display("FAIL reset_dark: dig_n low in %0d cycles, required 0", lows);
        end
        checks++;
        if (ticks != 2) begin
            errors++;
            $display("FAIL frame_period: %0d ticks in 64 clk, required 2", ticks);
        end
    endtask

    task automatic test_capture();
        bus.nL = ~4'h5;
        repeat (3) @(negedge clk);
        bus.ND = 1'b0;
        repeat (2) @(negedge clk);
        bus.ND = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.digit_count !== 4'd0) begin
            errors++;
            $display("FAIL capture_early: digit_count=%0d after 2 edges, required 0", bus.digit_count);
        end
        @(negedge clk);
        checks++;
        if (bus.digit_count !== 4'd1) begin
            errors++;
            $display("FAIL capture_latency: digit_count=%0d after 3 edges, required 1", bus.digit_count);
        end
        at_slot(0, BC - 1);
        checks++;
        if (bus.dig_n !== 4'b1111 || bus.seg !== 7'h00) begin
            errors++;
            $display("FAIL blank_window: dig_n=%b seg=%h required 1111 00", bus.dig_n, bus.seg);
        end
        at_slot(0, BC);
        checks++;
        if (bus.dig_n !== 4'b1110 || bus.seg !== exp_seg(4'h5)) begin
            errors++;
            $display("FAIL slot0_digit5: dig_n=%b seg=%h required 1110 %h", bus.dig_n, bus.seg, exp_seg(4'h5));
        end
        check_slot("slot1_dark", 1, 4'b1111, 7'h00);
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h7};
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        checks++;
        if (bus.digit_count !== 4'd0) begin
            errors++;
            $display("FAIL clr_count: digit_count=%0d required 0", bus.digit_count);
        end
        check_slot("clr_slot0_dark", 0, 4'b1111, 7'h00);
        foreach (seq[i]) strobe(seq[i]);
        checks++;
        if (bus.digit_count !== 4'd4) begin
            errors++;
            $display("FAIL count_saturate: digit_count=%0d required 4", bus.digit_count);
        end
        check_slot("slot3_digit2", 3, 4'b0111, exp_seg(4'h2));
        check_slot("slot0_digit7", 0, 4'b1110, exp_seg(4'h7));
    endtask

    task automatic test_clr_capture();
        bus.nL = ~4'hA;
        repeat (3) @(negedge clk);
        bus.ND = 1'b0;
        repeat (2) @(negedge clk);
        bus.ND = 1'b1;
        repeat (2) @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        checks++;
        if (bus.digit_count !== 4'd1) begin
            errors++;
            $display("FAIL clr_cap_count: digit_count=%0d required 1", bus.digit_count);
        end
        check_slot("clr_cap_slot0", 0, 4'b1110, exp_seg(4'hA));
        check_slot("clr_cap_slot1", 1, 4'b1111, 7'h00);
        check_slot("clr_cap_slot3", 3, 4'b1111, 7'h00);
    endtask

    task automatic test_reset_mid();
        at_slot(2, BC + 1);
        RESET = 1'b0;
        #1;
        checks++;
        if (bus.dig_n !== 4'b1111 || bus.seg !== 7'h00 || bus.digit_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid: dig_n=%b seg=%h cnt=%0d required 1111 00 0",
                     bus.dig_n, bus.seg, bus.digit_count);
        end
        repeat (2) @(negedge clk);
        RESET = 1'b1;
        count_to_tick("reset_mid_restart");
    endtask

    initial begin
        test_reset();
        test_capture();
        test_back_to_back();
        test_clr_capture();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
